// File: rtl/fsm_pkg.sv
// Shared types and constants for the fixed-pattern / PRBS-7 serial generator.
// Holds the state encoding, LFSR width, default pattern/seed and the LFSR step.
package fsm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PAT  = 2'd1,
      PRBS = 2'd2
   } state_e;

   localparam int              LFSR_W      = 7;
   localparam logic [7:0]      DEF_PATTERN = 8'hA5;
   localparam logic [LFSR_W-1:0] DEF_SEED  = 7'h7F;

   // x^7 + x^6 + 1: shift left, feed back bit6 ^ bit5 into bit0.
   function automatic logic [LFSR_W-1:0] prbs7_next(input logic [LFSR_W-1:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// PRBS-7 shift register with synchronous load and enable; MSB is the serial bit.
// Load takes priority over enable so a fresh entry always starts from SEED.
module prbs7_lfsr
   import fsm_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic msb_o
);

   logic [LFSR_W-1:0] lfsr_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; the async reset loads SEED because all-zero is a lock-up state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else if (load_i) begin
         lfsr_q <= SEED;
      end else if (en_i) begin
         lfsr_q <= prbs7_next(lfsr_q);
      end
   end

   assign msb_o = lfsr_q[LFSR_W-1];

endmodule

// File: rtl/fsm.sv
// Serial test-vector generator: repeats a fixed pattern MSB first or emits PRBS-7.
// Pattern-to-PRBS switches wait for a pattern boundary; run=0 always wins.
module fsm
   import fsm_pkg::*;
#(
   parameter int                PAT_W   = 8,
   parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(DEF_PATTERN),
   parameter logic [LFSR_W-1:0] SEED    = DEF_SEED
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic mode,
   output logic vector
);

   localparam int               IDX_W    = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic             lfsr_load;
   logic             lfsr_en;
   logic             lfsr_msb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= IDX_LAST;
      end else if (!run) begin
         state_q <= IDLE;
         idx_q   <= IDX_LAST;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= mode ? PRBS : PAT;
               idx_q   <= IDX_LAST;
            end
            PAT: begin
               if (idx_q == '0) begin
                  idx_q <= IDX_LAST;
                  if (mode) state_q <= PRBS;
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            PRBS: begin
               idx_q <= IDX_LAST;
               if (!mode) state_q <= PAT;
            end
            default: begin
               state_q <= IDLE;
               idx_q   <= IDX_LAST;
            end
         endcase
      end
   end

   // Reload the LFSR on every PRBS entry so there is no resume-from-position.
   assign lfsr_load = run && mode &&
                      ((state_q == IDLE) || ((state_q == PAT) && (idx_q == '0)));
   assign lfsr_en   = (state_q == PRBS);

   prbs7_lfsr #(
      .SEED (SEED)
   ) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (lfsr_load),
      .en_i   (lfsr_en),
      .msb_o  (lfsr_msb)
   );

   // NOTE: the default assignment first keeps this decode free of inferred latches.
   always_comb begin
      vector = 1'b0;
      case (state_q)
         PAT:     vector = PATTERN[idx_q];
         PRBS:    vector = lfsr_msb;
         default: vector = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_fsm.sv
// Self-checking bench for fsm: directed scenarios plus randomized run/mode traffic
// compared against a sequence-level reference model.
module tb_fsm;
   import fsm_pkg::*;

   localparam int         PAT_W    = 8;
   localparam logic [7:0] PATTERN  = 8'hA5;
   localparam logic [6:0] SEED     = 7'h7F;
   localparam int         PRBS_LEN = 127;

   logic clk = 1'b0;
   logic rst_n;
   logic run;
   logic mode;
   logic vector;

   int checks   = 0;
   int failures = 0;

   // Reference model: what is being emitted and where in its sequence we are.
   bit prbs_seq [PRBS_LEN];
   int m_kind;   // 0 = nothing, 1 = fixed pattern, 2 = pseudo-random
   int m_pos;    // bits of the pattern already shown, counted from the MSB
   int m_n;      // position within the 127-bit PRBS sequence

   always #5 clk = ~clk;

   fsm #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN),
      .SEED    (SEED)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (run),
      .mode   (mode),
      .vector (vector)
   );

   task automatic build_prbs();
      logic [6:0] s;
      s = SEED;
      for (int k = 0; k < 7; k++) prbs_seq[k] = s[6-k];
      for (int k = 7; k < PRBS_LEN; k++) prbs_seq[k] = prbs_seq[k-7] ^ prbs_seq[k-6];
   endtask

   function automatic bit model_vec();
      case (m_kind)
         1:       return PATTERN[PAT_W-1-m_pos];
         2:       return prbs_seq[m_n];
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_step(input bit r, input bit m);
      if (!r) begin
         m_kind = 0;
      end else begin
         case (m_kind)
            0: begin
               if (m) begin m_kind = 2; m_n = 0; end
               else   begin m_kind = 1; m_pos = 0; end
            end
            1: begin
               if (m_pos == PAT_W-1) begin
                  if (m) begin m_kind = 2; m_n = 0; end
                  else   m_pos = 0;
               end else begin
                  m_pos++;
               end
            end
            default: begin
               if (!m) begin m_kind = 1; m_pos = 0; end
               else   m_n = (m_n + 1) % PRBS_LEN;
            end
         endcase
      end
   endtask

   // Apply inputs, let one rising edge sample them, settle, advance the model.
   task automatic cycle(input bit r, input bit m);
      run  = r;
      mode = m;
      @(posedge clk);
      model_step(r, m);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      run    = 1'b1;
      mode   = 1'b0;
      m_kind = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         checks++;
         if (vector !== 1'b0) begin
            failures++;
            $display("FAIL reset_vector: vector=%0b expected 0", vector);
         end
         checks++;
         if (dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL reset_state: state=%0d expected %0d", dut.state_q, IDLE);
         end
      end
      @(negedge clk);
      run   = 1'b0;
      rst_n = 1'b1;
      #1;
      cycle(1'b0, 1'b0);
      checks++;
      if (vector !== model_vec()) begin
         failures++;
         $display("FAIL reset_release: vector=%0b expected %0b", vector, model_vec());
      end
   endtask

   task automatic test_fixed_pattern();
      bit exp_bits [10] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 0};
      repeat (5) begin
         cycle(1'b0, 1'b0);
         checks++;
         if (vector !== 1'b0) begin
            failures++;
            $display("FAIL idle_vector: vector=%0b expected 0", vector);
         end
      end
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0);
         checks++;
         if (vector !== exp_bits[i]) begin
            failures++;
            $display("FAIL fixed_pattern[%0d]: vector=%0b expected %0b", i, vector, exp_bits[i]);
         end
      end
   endtask

   task automatic test_pat_to_prbs();
      bit exp_bits [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
      int pat_cycles;
      bit entered;
      cycle(1'b0, 1'b0);
      repeat (3) cycle(1'b1, 1'b0);
      pat_cycles = 0;
      entered    = 1'b0;
      for (int i = 0; i < 20 && !entered; i++) begin
         cycle(1'b1, 1'b1);
         if (m_kind == 2) begin
            entered = 1'b1;
         end else begin
            pat_cycles++;
            checks++;
            if (vector !== model_vec()) begin
               failures++;
               $display("FAIL pat_finish[%0d]: vector=%0b expected %0b", i, vector, model_vec());
            end
         end
      end
      checks++;
      if (!entered || pat_cycles != PAT_W-3) begin
         failures++;
         $display("FAIL pat_boundary: pattern cycles after mode=1 were %0d, expected %0d", pat_cycles, PAT_W-3);
      end
      for (int i = 0; i < 8; i++) begin
         if (i > 0) cycle(1'b1, 1'b1);
         checks++;
         if (vector !== exp_bits[i]) begin
            failures++;
            $display("FAIL prbs_start[%0d]: vector=%0b expected %0b", i, vector, exp_bits[i]);
         end
      end
   endtask

   task automatic test_prbs_period();
      bit seen [254];
      int bad_period;
      int zero_hits;
      bad_period = 0;
      zero_hits  = 0;
      for (int i = 0; i < 254; i++) begin
         cycle(1'b1, 1'b1);
         seen[i] = vector;
         if (dut.u_lfsr.lfsr_q == 7'd0) zero_hits++;
         checks++;
         if (vector !== model_vec()) begin
            failures++;
            $display("FAIL prbs_seq[%0d]: vector=%0b expected %0b", i, vector, model_vec());
         end
      end
      for (int i = 0; i < PRBS_LEN; i++) if (seen[i] != seen[i+PRBS_LEN]) bad_period++;
      checks++;
      if (bad_period != 0) begin
         failures++;
         $display("FAIL prbs_period: %0d bits differ across 127-bit period, expected 0", bad_period);
      end
      checks++;
      if (zero_hits != 0) begin
         failures++;
         $display("FAIL prbs_nonzero: lfsr zero on %0d cycles, expected 0", zero_hits);
      end
   endtask

   task automatic test_prbs_to_pat();
      bit exp_bits [4] = '{1, 0, 1, 0};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0);
         checks++;
         if (vector !== exp_bits[i]) begin
            failures++;
            $display("FAIL prbs_to_pat[%0d]: vector=%0b expected %0b", i, vector, exp_bits[i]);
         end
      end
   endtask

   task automatic test_stop_and_reset();
      bit exp_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      cycle(1'b0, 1'b0);
      repeat (4) cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b0);
      checks++;
      if (vector !== 1'b0 || dut.state_q !== IDLE) begin
         failures++;
         $display("FAIL stop_prbs: vector=%0b state=%0d expected 0 and %0d", vector, dut.state_q, IDLE);
      end
      repeat (4) cycle(1'b1, 1'b0);
      // Asynchronous reset pulse between clock edges, mid-pattern.
      rst_n = 1'b0;
      #2;
      m_kind = 0;
      checks++;
      if (vector !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: vector=%0b expected 0", vector);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0);
         checks++;
         if (vector !== exp_bits[i]) begin
            failures++;
            $display("FAIL restart_pattern[%0d]: vector=%0b expected %0b", i, vector, exp_bits[i]);
         end
      end
   endtask

   task automatic test_random();
      bit r;
      bit m;
      m = 1'b0;
      for (int i = 0; i < 800; i++) begin
         r = ($urandom_range(0, 99) < 90);
         if ($urandom_range(0, 99) < 12) m = ~m;
         cycle(r, m);
         checks++;
         if (vector !== model_vec()) begin
            failures++;
            $display("FAIL random[%0d]: vector=%0b expected %0b", i, vector, model_vec());
         end
      end
   endtask

   initial begin
      run   = 1'b0;
      mode  = 1'b0;
      m_pos = 0;
      m_n   = 0;
      build_prbs();
      test_reset();
      test_fixed_pattern();
      test_pat_to_prbs();
      test_prbs_period();
      test_prbs_to_pat();
      test_stop_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
